// File: rtl/kitchen_pkg.sv
// Shared codes for the kitchen game: grid objects, player states, facing
// directions, game states and the frame-update FSM states.
package kitchen_pkg;

    typedef enum logic [3:0] {
        OBJ_EMPTY         = 4'd0,
        OBJ_ONION_WHOLE   = 4'd1,
        OBJ_ONION_CHOPPED = 4'd2,
        OBJ_BOWL_EMPTY    = 4'd3,
        OBJ_BOWL_FULL     = 4'd4,
        OBJ_POT_EMPTY     = 4'd5,
        OBJ_POT_RAW       = 4'd6,
        OBJ_POT_COOKED    = 4'd7,
        OBJ_POT_FIRE      = 4'd8,
        OBJ_FIRE          = 4'd9,
        OBJ_EXTINGUISHER  = 4'd10
    } obj_t;

    // Held-item codes 1..5 deliberately equal the matching grid codes.
    typedef enum logic [3:0] {
        PS_NOTHING       = 4'd0,
        PS_ONION_WHOLE   = 4'd1,
        PS_ONION_CHOPPED = 4'd2,
        PS_BOWL_EMPTY    = 4'd3,
        PS_BOWL_FULL     = 4'd4,
        PS_POT_EMPTY     = 4'd5,
        PS_CHOPPING      = 4'd6,
        PS_EXT_OFF       = 4'd7,
        PS_EXT_ON        = 4'd8
    } pstate_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        GS_MENU  = 3'd0,
        GS_PLAY  = 3'd1,
        GS_PAUSE = 3'd2,
        GS_OVER  = 3'd3
    } game_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAYER = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_FINISH = 2'd3
    } fsm_t;

    function automatic logic [3:0] obj_to_held(input logic [3:0] obj);
        case (obj)
            OBJ_ONION_WHOLE:   return PS_ONION_WHOLE;
            OBJ_ONION_CHOPPED: return PS_ONION_CHOPPED;
            OBJ_BOWL_EMPTY:    return PS_BOWL_EMPTY;
            OBJ_POT_EMPTY:     return PS_POT_EMPTY;
            OBJ_EXTINGUISHER:  return PS_EXT_OFF;
            default:           return PS_NOTHING;
        endcase
    endfunction

    function automatic logic [3:0] held_to_obj(input logic [3:0] ps);
        case (ps)
            PS_ONION_WHOLE:   return OBJ_ONION_WHOLE;
            PS_ONION_CHOPPED: return OBJ_ONION_CHOPPED;
            PS_BOWL_EMPTY:    return OBJ_BOWL_EMPTY;
            PS_BOWL_FULL:     return OBJ_BOWL_FULL;
            PS_POT_EMPTY:     return OBJ_POT_EMPTY;
            PS_EXT_OFF:       return OBJ_EXTINGUISHER;
            PS_EXT_ON:        return OBJ_EXTINGUISHER;
            default:          return OBJ_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/front_cell.sv
// Cell in front of a player: (gx,gy) stepped once along dir, with valid
// low when either the player or the stepped cell lies outside the grid.
module front_cell
    import kitchen_pkg::*;
#(
    parameter int GRID_W = 13,
    parameter int GRID_H = 8
)(
    input  logic [3:0] gx,
    input  logic [2:0] gy,
    input  logic [1:0] dir,
    output logic [3:0] tx,
    output logic [2:0] ty,
    output logic       valid
);
    localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
    localparam logic [2:0] Y_MAX = 3'(GRID_H - 1);

    logic in_grid_s;

    // Step one cell in the facing direction, flagging grid-edge overflow.
    always_comb begin
        tx        = gx;
        ty        = gy;
        in_grid_s = (gx <= X_MAX) && (gy <= Y_MAX);
        valid     = 1'b0;
        case (dir)
            DIR_LEFT: begin
                tx    = gx - 4'd1;
                valid = in_grid_s && (gx != 4'd0);
            end
            DIR_RIGHT: begin
                tx    = gx + 4'd1;
                valid = in_grid_s && (gx != X_MAX);
            end
            DIR_UP: begin
                ty    = gy - 3'd1;
                valid = in_grid_s && (gy != 3'd0);
            end
            DIR_DOWN: begin
                ty    = gy + 3'd1;
                valid = in_grid_s && (gy != Y_MAX);
            end
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/kitchen_action.sv
// Per-frame kitchen update: one cycle per player interaction, then one cycle
// per grid cell advancing pot timers, then a single-cycle done pulse.
module kitchen_action
    import kitchen_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int GRID_W      = 13,
    parameter int GRID_H      = 8,
    parameter int TIMER_W     = 8,
    parameter int CHOP_FRAMES = 30,
    parameter int COOK_FRAMES = 120,
    parameter int BURN_FRAMES = 200
)(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_tick,
    input  logic [2:0]                        game_state,
    input  logic [NUM_PLAYERS-1:0]            carry,
    input  logic [NUM_PLAYERS-1:0]            chop,
    input  logic [NUM_PLAYERS*2-1:0]          dir,
    input  logic [NUM_PLAYERS*4-1:0]          gx,
    input  logic [NUM_PLAYERS*3-1:0]          gy,
    output logic [NUM_PLAYERS*4-1:0]          player_state,
    output logic [GRID_H*GRID_W*4-1:0]        object_grid,
    output logic [GRID_H*GRID_W*TIMER_W-1:0]  time_grid,
    output logic                              busy,
    output logic                              done,
    output logic                              overrun
);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int CW    = $clog2(NCELL);
    localparam int PW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
    localparam int KW    = $clog2(CHOP_FRAMES + 1);
    localparam logic [TIMER_W-1:0] COOK_T = TIMER_W'(COOK_FRAMES);
    localparam logic [TIMER_W-1:0] BURN_T = TIMER_W'(BURN_FRAMES);
    localparam logic [KW-1:0]      CHOP_T = KW'(CHOP_FRAMES);
    localparam logic [PW-1:0]      P_LAST = PW'(NUM_PLAYERS - 1);
    localparam logic [CW-1:0]      C_LAST = CW'(NCELL - 1);

    function automatic logic [3:0] init_obj(input int idx);
        int r;
        int c;
        r = idx / GRID_W;
        c = idx % GRID_W;
        if ((r == 2 || r == 3) && c == 0)            return OBJ_ONION_WHOLE;
        else if (r == 6 && c == GRID_W - 1)          return OBJ_BOWL_EMPTY;
        else if (r == 0 && c >= 8 && c <= 11)        return OBJ_POT_EMPTY;
        else if (r == GRID_H - 1 && c == 0)          return OBJ_EXTINGUISHER;
        else                                         return OBJ_EMPTY;
    endfunction

    fsm_t                state_r, state_s;
    logic [PW-1:0]       pidx_r;
    logic [CW-1:0]       cidx_r;
    logic [3:0]          obj_r [NCELL];
    logic [TIMER_W-1:0]  tim_r [NCELL];
    logic [3:0]          ps_r  [NUM_PLAYERS];
    logic [KW-1:0]       cnt_r [NUM_PLAYERS];
    logic [1:0]          dir_r [NUM_PLAYERS];
    logic [3:0]          gx_r  [NUM_PLAYERS];
    logic [2:0]          gy_r  [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] carry_cur_r, carry_prev_r, chop_r;
    logic                busy_r, done_r, overrun_r;

    logic                accept_s;
    logic [3:0]          tx_s;
    logic [2:0]          ty_s;
    logic                tvalid_s;
    logic [CW-1:0]       tcell_s;
    logic [3:0]          tobj_s, cur_ps_s, held_s, new_ps_s, wr_obj_s;
    logic [KW-1:0]       cur_cnt_s, cnt_inc_s, new_cnt_s;
    logic                carry_edge_s, chop_cur_s, wr_en_s;
    logic [3:0]          sw_obj_s;
    logic [TIMER_W-1:0]  sw_tim_s, tim_inc_s;

    assign accept_s = (state_r == ST_IDLE) && frame_tick && (game_state == GS_PLAY);

    front_cell #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_front_cell (
        .gx    (gx_r[pidx_r]),
        .gy    (gy_r[pidx_r]),
        .dir   (dir_r[pidx_r]),
        .tx    (tx_s),
        .ty    (ty_s),
        .valid (tvalid_s)
    );

    // Select the player being served this cycle and the cell it faces.
    always_comb begin
        tcell_s      = CW'(32'(ty_s) * GRID_W + 32'(tx_s));
        tobj_s       = obj_r[tcell_s];
        cur_ps_s     = ps_r[pidx_r];
        cur_cnt_s    = cnt_r[pidx_r];
        cnt_inc_s    = cur_cnt_s + KW'(1);
        carry_edge_s = carry_cur_r[pidx_r] & ~carry_prev_r[pidx_r];
        chop_cur_s   = chop_r[pidx_r];
        held_s       = obj_to_held(tobj_s);
    end

    // Player interaction rules; a carry edge suppresses all chop handling.
    always_comb begin
        new_ps_s  = cur_ps_s;
        new_cnt_s = cur_cnt_s;
        wr_en_s   = 1'b0;
        wr_obj_s  = tobj_s;
        if (!tvalid_s) begin
            if (cur_ps_s == PS_CHOPPING) begin
                new_ps_s  = PS_NOTHING;
                new_cnt_s = '0;
            end else begin
                new_ps_s  = cur_ps_s;
            end
        end else if (carry_edge_s) begin
            case (cur_ps_s)
                PS_NOTHING: begin
                    if (held_s != PS_NOTHING) begin
                        new_ps_s = held_s;
                        wr_en_s  = 1'b1;
                        wr_obj_s = OBJ_EMPTY;
                    end else begin
                        new_ps_s = cur_ps_s;
                    end
                end
                PS_CHOPPING: new_ps_s = cur_ps_s;
                default: begin
                    if (tobj_s == OBJ_EMPTY) begin
                        new_ps_s = PS_NOTHING;
                        wr_en_s  = 1'b1;
                        wr_obj_s = held_to_obj(cur_ps_s);
                    end else if (cur_ps_s == PS_ONION_CHOPPED && tobj_s == OBJ_POT_EMPTY) begin
                        new_ps_s = PS_NOTHING;
                        wr_en_s  = 1'b1;
                        wr_obj_s = OBJ_POT_RAW;
                    end else if (cur_ps_s == PS_BOWL_EMPTY && tobj_s == OBJ_POT_COOKED) begin
                        new_ps_s = PS_BOWL_FULL;
                        wr_en_s  = 1'b1;
                        wr_obj_s = OBJ_POT_EMPTY;
                    end else begin
                        new_ps_s = cur_ps_s;
                    end
                end
            endcase
        end else begin
            case (cur_ps_s)
                PS_NOTHING: begin
                    if (chop_cur_s && tobj_s == OBJ_ONION_WHOLE) begin
                        new_ps_s  = PS_CHOPPING;
                        new_cnt_s = KW'(1);
                    end else begin
                        new_ps_s  = cur_ps_s;
                    end
                end
                PS_CHOPPING: begin
                    if (chop_cur_s && tobj_s == OBJ_ONION_WHOLE) begin
                        if (cnt_inc_s == CHOP_T) begin
                            new_ps_s  = PS_NOTHING;
                            new_cnt_s = '0;
                            wr_en_s   = 1'b1;
                            wr_obj_s  = OBJ_ONION_CHOPPED;
                        end else begin
                            new_cnt_s = cnt_inc_s;
                        end
                    end else begin
                        new_ps_s  = PS_NOTHING;
                        new_cnt_s = '0;
                    end
                end
                PS_EXT_OFF, PS_EXT_ON: begin
                    if (chop_cur_s) begin
                        new_ps_s = PS_EXT_ON;
                        if (tobj_s == OBJ_FIRE) begin
                            wr_en_s  = 1'b1;
                            wr_obj_s = OBJ_EMPTY;
                        end else if (tobj_s == OBJ_POT_FIRE) begin
                            wr_en_s  = 1'b1;
                            wr_obj_s = OBJ_POT_EMPTY;
                        end else begin
                            wr_en_s  = 1'b0;
                        end
                    end else begin
                        new_ps_s = PS_EXT_OFF;
                    end
                end
                default: new_ps_s = cur_ps_s;
            endcase
        end
    end

    // Pot timers during the sweep; timers saturate rather than wrap.
    always_comb begin
        sw_obj_s  = obj_r[cidx_r];
        sw_tim_s  = tim_r[cidx_r];
        tim_inc_s = (sw_tim_s == {TIMER_W{1'b1}}) ? sw_tim_s : sw_tim_s + TIMER_W'(1);
        if (sw_obj_s == OBJ_POT_RAW) begin
            if (tim_inc_s == COOK_T) begin
                sw_obj_s = OBJ_POT_COOKED;
                sw_tim_s = '0;
            end else begin
                sw_tim_s = tim_inc_s;
            end
        end else if (sw_obj_s == OBJ_POT_COOKED) begin
            if (tim_inc_s == BURN_T) begin
                sw_obj_s = OBJ_POT_FIRE;
                sw_tim_s = '0;
            end else begin
                sw_tim_s = tim_inc_s;
            end
        end else begin
            sw_tim_s = tim_r[cidx_r];
        end
    end

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = accept_s ? ST_PLAYER : ST_IDLE;
            ST_PLAYER: state_s = (pidx_r == P_LAST) ? ST_SWEEP : ST_PLAYER;
            ST_SWEEP:  state_s = (cidx_r == C_LAST) ? ST_FINISH : ST_SWEEP;
            ST_FINISH: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Sequencer state, walk indices and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pidx_r    <= '0;
            cidx_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s != ST_IDLE);
            done_r    <= (state_s == ST_FINISH);
            overrun_r <= frame_tick && (state_r != ST_IDLE);
            case (state_r)
                ST_PLAYER: pidx_r <= (pidx_r == P_LAST) ? '0 : pidx_r + PW'(1);
                ST_SWEEP:  cidx_r <= (cidx_r == C_LAST) ? '0 : cidx_r + CW'(1);
                default: begin
                    pidx_r <= '0;
                    cidx_r <= '0;
                end
            endcase
        end
    end

    // Player inputs are frozen at the accepted tick so a pass sees one frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_cur_r  <= '0;
            carry_prev_r <= '0;
            chop_r       <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                ps_r[i]  <= PS_NOTHING;
                cnt_r[i] <= '0;
                dir_r[i] <= 2'd0;
                gx_r[i]  <= 4'd0;
                gy_r[i]  <= 3'd0;
            end
        end else begin
            if (accept_s) begin
                carry_prev_r <= carry_cur_r;
                carry_cur_r  <= carry;
                chop_r       <= chop;
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    dir_r[i] <= dir[i*2 +: 2];
                    gx_r[i]  <= gx[i*4 +: 4];
                    gy_r[i]  <= gy[i*3 +: 3];
                end
            end
            if (state_r == ST_PLAYER) begin
                ps_r[pidx_r]  <= new_ps_s;
                cnt_r[pidx_r] <= new_cnt_s;
            end
        end
    end

    // Grid storage: player writes in PLAYER, timer/cook updates in SWEEP.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCELL; i++) begin
                obj_r[i] <= init_obj(i);
                tim_r[i] <= '0;
            end
        end else if (state_r == ST_PLAYER && wr_en_s) begin
            obj_r[tcell_s] <= wr_obj_s;
            tim_r[tcell_s] <= '0;
        end else if (state_r == ST_SWEEP) begin
            obj_r[cidx_r] <= sw_obj_s;
            tim_r[cidx_r] <= sw_tim_s;
        end
    end

    // Flatten register arrays onto the output buses.
    always_comb begin
        player_state = '0;
        object_grid  = '0;
        time_grid    = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            player_state[i*4 +: 4] = ps_r[i];
        end
        for (int i = 0; i < NCELL; i++) begin
            object_grid[i*4 +: 4]             = obj_r[i];
            time_grid[i*TIMER_W +: TIMER_W]   = tim_r[i];
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign overrun = overrun_r;
endmodule

// File: tb/tb_kitchen_action.sv
// Directed bench for kitchen_action: pickup/place, chopping, cooking to fire,
// extinguishing, player priority, overrun and mid-pass reset.
module tb_kitchen_action;
    import kitchen_pkg::*;

    localparam int GW = 13;
    localparam int GH = 8;
    localparam int TW = 8;
    localparam int PASS_LEN = 2 + GW * GH + 1;

    logic              clk = 1'b0;
    logic              reset, frame_tick;
    logic [2:0]        game_state;
    logic [1:0]        carry, chop;
    logic [3:0]        dir;
    logic [7:0]        gx;
    logic [5:0]        gy;
    logic [7:0]        player_state;
    logic [GH*GW*4-1:0]  object_grid;
    logic [GH*GW*TW-1:0] time_grid;
    logic              busy, done, overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int last_cycles;

    kitchen_action dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .game_state   (game_state),
        .carry        (carry),
        .chop         (chop),
        .dir          (dir),
        .gx           (gx),
        .gy           (gy),
        .player_state (player_state),
        .object_grid  (object_grid),
        .time_grid    (time_grid),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int obj_at(input int r, input int c);
        return int'(object_grid[(r*GW + c)*4 +: 4]);
    endfunction

    function automatic int tim_at(input int r, input int c);
        return int'(time_grid[(r*GW + c)*TW +: TW]);
    endfunction

    function automatic int ps_of(input int p);
        return int'(player_state[p*4 +: 4]);
    endfunction

    function automatic logic [GH*GW*4-1:0] reset_grid();
        logic [GH*GW*4-1:0] g;
        g = '0;
        g[(2*GW + 0)*4 +: 4]    = 4'd1;
        g[(3*GW + 0)*4 +: 4]    = 4'd1;
        g[(6*GW + 12)*4 +: 4]   = 4'd3;
        for (int c = 8; c <= 11; c++) g[c*4 +: 4] = 4'd5;
        g[(7*GW + 0)*4 +: 4]    = 4'd10;
        return g;
    endfunction

    task automatic place(input int p, input int x, input int y, input int d);
        gx[p*4 +: 4]  = 4'(x);
        gy[p*3 +: 3]  = 3'(y);
        dir[p*2 +: 2] = 2'(d);
    endtask

    task automatic run_pass();
        int cyc;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        last_cycles = cyc;
        if (!done) check("pass_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_passes(input int n);
        for (int k = 0; k < n; k++) run_pass();
    endtask

    initial begin
        int cyc;
        reset = 1'b1; frame_tick = 1'b0; game_state = GS_PLAY;
        carry = 2'b00; chop = 2'b00; gx = '0; gy = '0; dir = '0;
        place(0, 5, 4, DIR_DOWN);
        place(1, 5, 5, DIR_DOWN);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_players", player_state, 0);
        check("rst_grid", int'(object_grid == reset_grid()), 1);
        check("rst_time", int'(|time_grid), 0);

        // tick outside PLAY is ignored
        game_state = GS_MENU;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk);
        check("menu_ignored", busy, 0);
        game_state = GS_PLAY;

        run_pass();
        check("pass_len", last_cycles, PASS_LEN);
        check("idle_grid", int'(object_grid == reset_grid()), 1);
        check("idle_busy_after", busy, 0);

        // pickup onion; P1 faces off the right edge and must not wrap
        place(0, 1, 2, DIR_LEFT);
        place(1, 12, 6, DIR_RIGHT);
        carry = 2'b11;
        run_pass();
        check("pick_ps0", ps_of(0), PS_ONION_WHOLE);
        check("pick_cell", obj_at(2, 0), OBJ_EMPTY);
        check("offgrid_ps1", ps_of(1), PS_NOTHING);
        check("offgrid_ext", obj_at(7, 0), OBJ_EXTINGUISHER);

        place(1, 5, 5, DIR_DOWN);
        place(0, 1, 2, DIR_RIGHT);
        carry = 2'b00;
        run_pass();
        check("noedge_ps0", ps_of(0), PS_ONION_WHOLE);
        check("noedge_cell", obj_at(2, 2), OBJ_EMPTY);
        carry = 2'b01;
        run_pass();
        check("drop_ps0", ps_of(0), PS_NOTHING);
        check("drop_cell", obj_at(2, 2), OBJ_ONION_WHOLE);

        // chop released early leaves the onion whole
        carry = 2'b00;
        place(0, 1, 3, DIR_LEFT);
        chop = 2'b01;
        run_passes(14);
        check("chop14_ps0", ps_of(0), PS_CHOPPING);
        chop = 2'b00;
        run_pass();
        check("release_ps0", ps_of(0), PS_NOTHING);
        check("release_cell", obj_at(3, 0), OBJ_ONION_WHOLE);

        chop = 2'b01;
        run_passes(29);
        check("chop29_ps0", ps_of(0), PS_CHOPPING);
        check("chop29_cell", obj_at(3, 0), OBJ_ONION_WHOLE);
        run_pass();
        check("chop30_cell", obj_at(3, 0), OBJ_ONION_CHOPPED);
        check("chop30_ps0", ps_of(0), PS_NOTHING);
        chop = 2'b00;

        // chopped onion into pot, then cook and burn
        carry = 2'b01;
        run_pass();
        check("pick_chopped", ps_of(0), PS_ONION_CHOPPED);
        place(0, 8, 1, DIR_UP);
        carry = 2'b00;
        run_pass();
        carry = 2'b01;
        run_pass();
        check("pot_raw", obj_at(0, 8), OBJ_POT_RAW);
        check("pot_raw_t1", tim_at(0, 8), 1);
        check("pot_ps0", ps_of(0), PS_NOTHING);
        carry = 2'b00;
        run_passes(118);
        check("raw119_obj", obj_at(0, 8), OBJ_POT_RAW);
        check("raw119_t", tim_at(0, 8), 119);
        run_pass();
        check("cooked_obj", obj_at(0, 8), OBJ_POT_COOKED);
        check("cooked_t", tim_at(0, 8), 0);
        run_passes(199);
        check("cook199_obj", obj_at(0, 8), OBJ_POT_COOKED);
        check("cook199_t", tim_at(0, 8), 199);
        run_pass();
        check("fire_obj", obj_at(0, 8), OBJ_POT_FIRE);
        check("fire_t", tim_at(0, 8), 0);
        run_pass();
        check("fire_hold_t", tim_at(0, 8), 0);

        // extinguisher: pick up, spray pot fire, release, put back
        place(0, 1, 7, DIR_LEFT);
        carry = 2'b01;
        run_pass();
        check("ext_pick", ps_of(0), PS_EXT_OFF);
        check("ext_cell", obj_at(7, 0), OBJ_EMPTY);
        carry = 2'b00;
        place(0, 8, 1, DIR_UP);
        chop = 2'b01;
        run_passes(2);
        check("ext_on", ps_of(0), PS_EXT_ON);
        check("ext_put_out", obj_at(0, 8), OBJ_POT_EMPTY);
        chop = 2'b00;
        run_pass();
        check("ext_off", ps_of(0), PS_EXT_OFF);
        place(0, 1, 7, DIR_LEFT);
        carry = 2'b01;
        run_pass();
        check("ext_back", obj_at(7, 0), OBJ_EXTINGUISHER);
        check("ext_back_ps0", ps_of(0), PS_NOTHING);

        // both players grab the same onion: lower index wins
        place(0, 1, 2, DIR_RIGHT);
        place(1, 3, 2, DIR_LEFT);
        carry = 2'b00;
        run_pass();
        carry = 2'b11;
        run_pass();
        check("race_ps0", ps_of(0), PS_ONION_WHOLE);
        check("race_ps1", ps_of(1), PS_NOTHING);
        check("race_cell", obj_at(2, 2), OBJ_EMPTY);

        // tick while busy: overrun pulse, pass length unchanged
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        frame_tick = 1'b1;
        @(negedge clk); cyc++;
        frame_tick = 1'b0;
        check("overrun_pulse", overrun, 1);
        @(negedge clk); cyc++;
        check("overrun_clear", overrun, 0);
        while (!done && cyc < 400) begin @(negedge clk); cyc++; end
        check("overrun_len", cyc, PASS_LEN);
        @(negedge clk);
        check("overrun_idle", busy, 0);

        // reset in the middle of the sweep
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_players", player_state, 0);
        check("mrst_grid", int'(object_grid == reset_grid()), 1);
        check("mrst_time", int'(|time_grid), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
